ni_packetizer: RTL and testbench



---
 rtl/ni_packetizer.sv | 153 +++++++++++++++
 tb/tb_ni_packetizer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_packetizer.sv
// Source-side network interface: turns packet requests plus payload words into HEAD/BODY/TAIL flits
// under credit-based flow control. Optional credit-error flag is enabled by defining NI_CREDIT_CHECK_EN.
module ni_packetizer #(
   parameter int x_Current       = 0,
   parameter int y_Current       = 0,
   parameter int x_Des_Addr_Size = 2,
   parameter int y_Des_Addr_Size = 2,
   parameter int FLIT_DATA_W     = 32,
   parameter int MAX_BODY        = 8,
   parameter int BUFFER_DEPTH    = 4,
   localparam int LEN_W          = $clog2(MAX_BODY + 1),
   localparam int CNT_W          = $clog2(BUFFER_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pkt_Valid,
   output logic                       pkt_Ready,
   input  logic [x_Des_Addr_Size-1:0] pkt_X_Dest,
   input  logic [y_Des_Addr_Size-1:0] pkt_Y_Dest,
   input  logic [LEN_W-1:0]           pkt_Len,
   input  logic                       data_Valid,
   output logic                       data_Ready,
   input  logic [FLIT_DATA_W-1:0]     data_In,
   output logic                       flit_Valid,
   output logic [FLIT_DATA_W+1:0]     flit_Out,
   input  logic                       credit_In,
`ifdef NI_CREDIT_CHECK_EN
   output logic                       cred_Err,
`endif
   output logic                       busy
);

   localparam int HDR_W = 2 * (x_Des_Addr_Size + y_Des_Addr_Size) + LEN_W;
   localparam logic [x_Des_Addr_Size-1:0] X_SRC = x_Des_Addr_Size'(x_Current);
   localparam logic [y_Des_Addr_Size-1:0] Y_SRC = y_Des_Addr_Size'(y_Current);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_DEPTH);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BODY);

   localparam logic [1:0] T_HEAD     = 2'b00;
   localparam logic [1:0] T_BODY     = 2'b01;
   localparam logic [1:0] T_TAIL     = 2'b10;
   localparam logic [1:0] T_HEADTAIL = 2'b11;

   if (FLIT_DATA_W < HDR_W) begin : g_width_check
      $error("ni_packetizer: FLIT_DATA_W too narrow for the head flit fields");
   end

   typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

   state_t                     state, next_state;
   logic [CNT_W-1:0]           credits;
   logic [LEN_W-1:0]           rem;
   logic [x_Des_Addr_Size-1:0] x_dest;
   logic [y_Des_Addr_Size-1:0] y_dest;
   logic                       accept, emit, has_credit, len_over;
   logic [LEN_W-1:0]           len_clamped;
   logic [1:0]                 flit_type;
   logic [FLIT_DATA_W-1:0]     flit_payload, head_payload;
   logic [HDR_W-1:0]           hdr;

   assign has_credit   = (credits != '0);
   assign accept       = pkt_Valid && pkt_Ready;
   assign len_over     = (pkt_Len > LEN_MAX);
   assign len_clamped  = len_over ? LEN_MAX : pkt_Len;
   // In HEAD, rem still holds the (clamped) packet length, so it doubles as the header len field.
   assign hdr          = {x_dest, y_dest, X_SRC, Y_SRC, rem};
   assign head_payload = FLIT_DATA_W'(hdr) << (FLIT_DATA_W - HDR_W);
   assign busy         = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state   = state;
      pkt_Ready    = 1'b0;
      data_Ready   = 1'b0;
      emit         = 1'b0;
      flit_type    = T_HEAD;
      flit_payload = '0;
      case (state)
         IDLE: begin
            pkt_Ready = !rst;
            if (pkt_Valid && !rst) next_state = HEAD;
         end
         HEAD: begin
            if (has_credit) begin
               emit         = 1'b1;
               flit_payload = head_payload;
               if (rem == '0) begin
                  flit_type  = T_HEADTAIL;
                  next_state = IDLE;
               end else begin
                  flit_type  = T_HEAD;
                  next_state = BODY;
               end
            end
         end
         BODY: begin
            data_Ready = has_credit && !rst;
            if (data_Valid && data_Ready) begin
               emit         = 1'b1;
               flit_payload = data_In;
               if (rem == LEN_W'(1)) begin
                  flit_type  = T_TAIL;
                  next_state = IDLE;
               end else begin
                  flit_type  = T_BODY;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Emission and a returned credit in the same cycle cancel; a credit at full count is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         credits    <= FULL;
         rem        <= '0;
         x_dest     <= '0;
         y_dest     <= '0;
         flit_Valid <= 1'b0;
         flit_Out   <= '0;
      end else begin
         flit_Valid <= emit;
         if (emit) flit_Out <= {flit_type, flit_payload};
         if (accept) begin
            x_dest <= pkt_X_Dest;
            y_dest <= pkt_Y_Dest;
            rem    <= len_clamped;
         end else if (emit && state == BODY) begin
            rem <= rem - LEN_W'(1);
         end
         case ({emit, credit_In})
            2'b10:   credits <= credits - CNT_W'(1);
            2'b01:   if (credits != FULL) credits <= credits + CNT_W'(1);
            default: credits <= credits;
         endcase
      end
   end

`ifdef NI_CREDIT_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)
         cred_Err <= 1'b0;
      else if ((credit_In && !emit && credits == FULL) || (accept && len_over))
         cred_Err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed testbench for ni_packetizer (default parameters: source (0,0), 32-bit payload,
// MAX_BODY 8, BUFFER_DEPTH 4); the cred_Err checks compile in only with NI_CREDIT_CHECK_EN.
module tb_ni_packetizer;

   logic        clk;
   logic        rst;
   logic        pkt_Valid;
   logic        pkt_Ready;
   logic [1:0]  pkt_X_Dest;
   logic [1:0]  pkt_Y_Dest;
   logic [3:0]  pkt_Len;
   logic        data_Valid;
   logic        data_Ready;
   logic [31:0] data_In;
   logic        flit_Valid;
   logic [33:0] flit_Out;
   logic        credit_In;
   logic        busy;
`ifdef NI_CREDIT_CHECK_EN
   logic        cred_Err;
`endif

   ni_packetizer dut (
      .clk        (clk),
      .rst        (rst),
      .pkt_Valid  (pkt_Valid),
      .pkt_Ready  (pkt_Ready),
      .pkt_X_Dest (pkt_X_Dest),
      .pkt_Y_Dest (pkt_Y_Dest),
      .pkt_Len    (pkt_Len),
      .data_Valid (data_Valid),
      .data_Ready (data_Ready),
      .data_In    (data_In),
      .flit_Valid (flit_Valid),
      .flit_Out   (flit_Out),
      .credit_In  (credit_In),
`ifdef NI_CREDIT_CHECK_EN
      .cred_Err   (cred_Err),
`endif
      .busy       (busy)
   );

   int          testCount = 0;
   int          failCount = 0;
   int          cycle = 0;
   int          acceptCycle = 0;
   logic [33:0] flitQ[$];
   int          flitCyc[$];
   logic [31:0] dataQ[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Record every flit the router would sample, with the cycle it was presented in.
   always @(negedge clk) begin
      if (flit_Valid === 1'b1) begin
         flitQ.push_back(flit_Out);
         flitCyc.push_back(cycle);
      end
   end

   // Payload source: presents the head of dataQ and pops it once the handshake fires.
   initial begin : dataDriver
      logic fire;
      data_Valid = 1'b0;
      data_In    = '0;
      forever begin
         @(negedge clk);
         fire = data_Valid && data_Ready;
         @(posedge clk);
         #1;
         if (fire && dataQ.size() > 0) void'(dataQ.pop_front());
         if (dataQ.size() > 0) begin
            data_Valid = 1'b1;
            data_In    = dataQ[0];
         end else begin
            data_Valid = 1'b0;
            data_In    = '0;
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [33:0] mkFlit(input logic [1:0] t, input logic [31:0] p);
      return {t, p};
   endfunction

   task automatic checkFlit(input string tag, input int idx, input logic [33:0] expected);
      if (idx < flitQ.size()) checkOutput(tag, 64'(flitQ[idx]), 64'(expected));
      else                    checkOutput(tag, {64{1'bx}}, 64'(expected));
   endtask

   task automatic checkGap(input string tag, input int base, input int i);
      if (base + i < flitCyc.size()) checkOutput(tag, 64'(flitCyc[base + i] - flitCyc[base]), 64'(i));
      else                           checkOutput(tag, {64{1'bx}}, 64'(i));
   endtask

   task automatic waitFlits(input int target, input int budget, input string tag);
      int k = 0;
      while (flitQ.size() < target && k < budget) begin
         waitCycles(1);
         k++;
      end
      checkOutput(tag, 64'(flitQ.size()), 64'(target));
   endtask

   // Raise a packet request and hold it until the edge where it is accepted.
   task automatic applyStimulus(input logic [1:0] x, input logic [1:0] y, input logic [3:0] len);
      int k = 0;
      pkt_X_Dest = x;
      pkt_Y_Dest = y;
      pkt_Len    = len;
      pkt_Valid  = 1'b1;
      @(negedge clk);
      while (pkt_Ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (pkt_Ready !== 1'b1) checkOutput("accept timeout", 64'(pkt_Ready), 64'(1));
      @(posedge clk);
      #1;
      pkt_Valid   = 1'b0;
      acceptCycle = cycle;
   endtask

   initial begin : main
      int base;
      int k;
      rst        = 1'b1;
      pkt_Valid  = 1'b0;
      pkt_X_Dest = '0;
      pkt_Y_Dest = '0;
      pkt_Len    = '0;
      credit_In  = 1'b0;
      waitCycles(3);

      checkOutput("rst pkt_Ready", 64'(pkt_Ready), 64'(0));
      checkOutput("rst flit_Valid", 64'(flit_Valid), 64'(0));
      checkOutput("rst flit_Out", 64'(flit_Out), 64'(0));
      checkOutput("rst busy", 64'(busy), 64'(0));
      checkOutput("rst data_Ready", 64'(data_Ready), 64'(0));
`ifdef NI_CREDIT_CHECK_EN
      checkOutput("rst cred_Err", 64'(cred_Err), 64'(0));
`endif
      rst = 1'b0;
      #1;
      checkOutput("idle pkt_Ready", 64'(pkt_Ready), 64'(1));

      // Zero-length packet: a single HEADTAIL flit one cycle after the edge following accept.
      base = flitQ.size();
      applyStimulus(2'd2, 2'd1, 4'd0);
      checkOutput("t1 busy", 64'(busy), 64'(1));
      waitFlits(base + 1, 10, "t1 count");
      checkFlit("t1 headtail", base, mkFlit(2'b11, 32'h9000_0000));
      if (base < flitCyc.size()) checkOutput("t1 latency", 64'(flitCyc[base] - acceptCycle), 64'(1));
      checkOutput("t1 busy idle", 64'(busy), 64'(0));
      credit_In = 1'b1;
      waitCycles(1);
      credit_In = 1'b0;
`ifdef NI_CREDIT_CHECK_EN
      checkOutput("t1 cred_Err", 64'(cred_Err), 64'(0));
`endif

      // Three body words back-to-back use all four credits in four consecutive cycles.
      base = flitQ.size();
      applyStimulus(2'd3, 2'd3, 4'd3);
      dataQ.push_back(32'hA);
      dataQ.push_back(32'hB);
      dataQ.push_back(32'hC);
      waitFlits(base + 4, 15, "t2 count");
      checkFlit("t2 head", base, mkFlit(2'b00, 32'hF030_0000));
      checkFlit("t2 body A", base + 1, mkFlit(2'b01, 32'hA));
      checkFlit("t2 body B", base + 2, mkFlit(2'b01, 32'hB));
      checkFlit("t2 tail C", base + 3, mkFlit(2'b10, 32'hC));
      checkGap("t2 gap", base, 3);

      // No credits left: the packet stalls; one credit lets exactly one flit through.
      base = flitQ.size();
      applyStimulus(2'd3, 2'd3, 4'd3);
      dataQ.push_back(32'h11);
      dataQ.push_back(32'h22);
      dataQ.push_back(32'h33);
      waitCycles(8);
      checkOutput("t3 stall count", 64'(flitQ.size()), 64'(base));
      checkOutput("t3 stall data_Ready", 64'(data_Ready), 64'(0));
      checkOutput("t3 stall busy", 64'(busy), 64'(1));
      credit_In = 1'b1;
      waitCycles(1);
      credit_In = 1'b0;
      waitCycles(4);
      checkOutput("t3 one flit", 64'(flitQ.size()), 64'(base + 1));
      checkFlit("t3 head", base, mkFlit(2'b00, 32'hF030_0000));
      checkOutput("t3 body data_Ready", 64'(data_Ready), 64'(0));
      waitCycles(4);
      checkOutput("t3 stall again", 64'(flitQ.size()), 64'(base + 1));
      credit_In = 1'b1;
      waitCycles(3);
      credit_In = 1'b0;
      waitFlits(base + 4, 10, "t3 count");
      checkFlit("t3 body 11", base + 1, mkFlit(2'b01, 32'h11));
      checkFlit("t3 body 22", base + 2, mkFlit(2'b01, 32'h22));
      checkFlit("t3 tail 33", base + 3, mkFlit(2'b10, 32'h33));
      credit_In = 1'b1;
      waitCycles(4);
      credit_In = 1'b0;

      // Credit returned on every emission: a maximum packet streams without a gap.
      base = flitQ.size();
      applyStimulus(2'd1, 2'd2, 4'd8);
      for (int i = 0; i < 8; i++) dataQ.push_back(32'h100 + 32'(i));
      credit_In = 1'b1;
      waitCycles(9);
      credit_In = 1'b0;
      waitFlits(base + 9, 5, "t4 count");
      checkFlit("t4 head", base, mkFlit(2'b00, 32'h6080_0000));
      for (int i = 0; i < 7; i++) checkFlit("t4 body", base + 1 + i, mkFlit(2'b01, 32'h100 + 32'(i)));
      checkFlit("t4 tail", base + 8, mkFlit(2'b10, 32'h107));
      checkGap("t4 gap", base, 8);
`ifdef NI_CREDIT_CHECK_EN
      checkOutput("t4 cred_Err", 64'(cred_Err), 64'(0));
`endif

      // Count must still be exactly four: a five-flit packet stops after four.
      base = flitQ.size();
      applyStimulus(2'd2, 2'd3, 4'd4);
      for (int i = 0; i < 4; i++) dataQ.push_back(32'h41 + 32'(i));
      waitCycles(12);
      checkOutput("t5a count", 64'(flitQ.size()), 64'(base + 4));
      checkFlit("t5a head", base, mkFlit(2'b00, 32'hB040_0000));
      checkFlit("t5a body 43", base + 3, mkFlit(2'b01, 32'h43));
      checkOutput("t5a data_Ready", 64'(data_Ready), 64'(0));
      rst = 1'b1;
      waitCycles(1);
      checkOutput("t5a pkt_Ready in rst", 64'(pkt_Ready), 64'(0));
      checkOutput("t5a busy in rst", 64'(busy), 64'(0));
      rst = 1'b0;
      dataQ.delete();
      waitCycles(2);

      // Reset right after the second body flit: no more flits, back to IDLE.
      base = flitQ.size();
      applyStimulus(2'd0, 2'd3, 4'd5);
      for (int i = 0; i < 5; i++) dataQ.push_back(32'h61 + 32'(i));
      k = 0;
      while (flitQ.size() < base + 3 && k < 30) begin
         @(negedge clk);
         #1;
         k++;
      end
      rst = 1'b1;
      waitCycles(2);
      checkOutput("t5 busy in rst", 64'(busy), 64'(0));
      rst = 1'b0;
      dataQ.delete();
      #1;
      checkOutput("t5 pkt_Ready", 64'(pkt_Ready), 64'(1));
      waitCycles(3);
      checkOutput("t5 count", 64'(flitQ.size()), 64'(base + 3));
      checkFlit("t5 head", base, mkFlit(2'b00, 32'h3050_0000));
      checkFlit("t5 body 62", base + 2, mkFlit(2'b01, 32'h62));
      checkOutput("t5 flit_Valid", 64'(flit_Valid), 64'(0));

      // Oversized length is clamped to eight; reset restored the full four credits.
      base = flitQ.size();
      applyStimulus(2'd1, 2'd1, 4'd12);
      for (int i = 0; i < 8; i++) dataQ.push_back(32'h71 + 32'(i));
      waitCycles(12);
      checkOutput("t6 count", 64'(flitQ.size()), 64'(base + 4));
      checkFlit("t6 clamped head", base, mkFlit(2'b00, 32'h5080_0000));
`ifdef NI_CREDIT_CHECK_EN
      checkOutput("t6 cred_Err clamp", 64'(cred_Err), 64'(1));
`endif
      rst = 1'b1;
      waitCycles(2);
      rst = 1'b0;
      dataQ.delete();
`ifdef NI_CREDIT_CHECK_EN
      checkOutput("t6 cred_Err cleared", 64'(cred_Err), 64'(0));
`endif
      waitCycles(2);

      // Surplus credits at full count are dropped, so only four flits go out.
      credit_In = 1'b1;
      waitCycles(2);
      credit_In = 1'b0;
`ifdef NI_CREDIT_CHECK_EN
      checkOutput("t7 cred_Err set", 64'(cred_Err), 64'(1));
`endif
      base = flitQ.size();
      applyStimulus(2'd3, 2'd0, 4'd4);
      for (int i = 0; i < 4; i++) dataQ.push_back(32'h81 + 32'(i));
      waitCycles(12);
      checkOutput("t7 count", 64'(flitQ.size()), 64'(base + 4));
      checkFlit("t7 head", base, mkFlit(2'b00, 32'hC040_0000));
      checkFlit("t7 body 83", base + 3, mkFlit(2'b01, 32'h83));
`ifdef NI_CREDIT_CHECK_EN
      checkOutput("t7 cred_Err sticky", 64'(cred_Err), 64'(1));
`endif
      rst = 1'b1;
      waitCycles(1);
      rst = 1'b0;
      dataQ.delete();
`ifdef NI_CREDIT_CHECK_EN
      checkOutput("t7 cred_Err rst", 64'(cred_Err), 64'(0));
`endif
      waitCycles(2);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
